id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the bubble counter.
REQ-002 The block SHALL have the port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port stall  input  1  downstream hold request; the register holds its contents.
REQ-005 The block SHALL have the port flush  input  1  branch/jump squash; the register loads a bubble.
REQ-006 The block SHALL have the ports id_pc4, id_rd1, id_rd2, id_imm  input  32 each  PC+4, register-file ReadData1/ReadData2, sign-extended immediate.
REQ-007 The block SHALL have the ports id_rs, id_rt, id_rd  input  5 each  instruction register fields.
REQ-008 The block SHALL have the ports id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst  input  1 each  decoded controls.
REQ-009 The block SHALL have the port id_ALUOp  input  2  ALU operation class.
REQ-010 The block SHALL have the ports ex_* outputs, each mirroring its id_* input with the same width and registered, plus ex_valid  output  1.
REQ-011 The block SHALL have the port load_use_stall  output  1  combinational; held by PC and IF/ID when asserted.
REQ-012 The block SHALL have the port bubble_cnt  output  CNT_W  count of hazard bubbles inserted.

Function
REQ-013 load_use_stall SHALL equal ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)), with no clock latency.
REQ-014 The register SHALL apply one action per posedge, in priority order: reset > flush > stall > load_use_stall > load.
REQ-015 On flush, the register SHALL capture a bubble: all ex_* controls and data 0, ex_valid 0.
REQ-016 On stall without flush, every ex_* output, ex_valid and bubble_cnt SHALL hold, even if load_use_stall is 1.
REQ-017 On load_use_stall without flush or stall, the register SHALL capture a bubble and bubble_cnt SHALL increment by 1.
REQ-018 Otherwise the register SHALL capture all id_* inputs with ex_valid = 1, giving 1-cycle latency from ID to EX.
REQ-019 bubble_cnt SHALL saturate at all-ones and never wrap.
REQ-020 A flush bubble SHALL NOT increment bubble_cnt.
REQ-021 The block SHALL perform no register-file access; id_rd1/id_rd2 are taken as valid in the cycle presented (the register file writes on negedge, so no write-back bypass is needed).

Reset
REQ-022 While reset = 1 at posedge, all ex_* outputs, ex_valid and bubble_cnt SHALL become 0, overriding flush and stall.
REQ-023 After reset, load_use_stall SHALL be 0, since ex_valid = 0.
REQ-024 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; the first post-reset load SHALL proceed normally.

Structure
REQ-025 A shared package cpu_pkg SHALL hold ALUOp encodings (00 add, 01 sub, 10 R-type, 11 reserved), register-index width 5 and data width 32.
REQ-026 Hazard comparison SHALL be a sub-module named load_use_detect, purely combinational, instantiated once.
REQ-027 All sequential logic SHALL use one posedge clk process with synchronous reset.

Verification
REQ-028 Scenario: reset, then load id_rd1=0x0000_00AA, id_rd2=0x0000_0055, id_RegWrite=1 -> the next cycle gives ex_rd1=0xAA, ex_rd2=0x55, ex_RegWrite=1, ex_valid=1.
REQ-029 Scenario: lw with rt=8 in EX, ID has rs=8 -> load_use_stall=1 the same cycle; the next cycle gives ex_valid=0, all controls 0, bubble_cnt=1; the re-presented instruction loads the following cycle.
REQ-030 Scenario: lw with rt=0 in EX, ID has rs=0 -> load_use_stall=0, and the instruction loads.
REQ-031 Scenario: stall=1 for 3 cycles with changing id_* -> ex_* hold the pre-stall values; a concurrent hazard does not change bubble_cnt.
REQ-032 Scenario: flush=1 with stall=1 and a hazard -> a bubble is captured and bubble_cnt is unchanged.
REQ-033 Scenario: force bubble_cnt to 0xFFFF and create a hazard -> bubble_cnt stays 0xFFFF; reset then gives bubble_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: data/register widths, ALU operation classes and
// the ID/EX payload carried between decode and execute.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              alu_src;
    logic              reg_dst;
    alu_op_e           alu_op;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction now in ID.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  // $zero never creates a dependency, so a load targeting it is ignored
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rt != REG_W'(0)) &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush, stall and load-use bubble insertion,
// plus a saturating count of hazard bubbles.
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       id_pc4,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic [1:0]        id_ALUOp,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_valid,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  id_ex_t           id_pl;
  id_ex_t           ex_d, ex_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ex_q.mem_read),
    .ex_rt       (ex_q.rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard)
  );

  // Gather decode-stage fields into one payload
  always_comb begin
    id_pl            = ID_EX_BUBBLE;
    id_pl.pc4        = id_pc4;
    id_pl.rd1        = id_rd1;
    id_pl.rd2        = id_rd2;
    id_pl.imm        = id_imm;
    id_pl.rs         = id_rs;
    id_pl.rt         = id_rt;
    id_pl.rd         = id_rd;
    id_pl.reg_write  = id_RegWrite;
    id_pl.mem_to_reg = id_MemtoReg;
    id_pl.mem_read   = id_MemRead;
    id_pl.mem_write  = id_MemWrite;
    id_pl.branch     = id_Branch;
    id_pl.alu_src    = id_ALUSrc;
    id_pl.reg_dst    = id_RegDst;
    id_pl.alu_op     = alu_op_e'(id_ALUOp);
  end

  // One action per edge: flush > stall > load-use bubble > load
  always_comb begin
    ex_d         = ex_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d    = ID_EX_BUBBLE;
      valid_d = 1'b0;
    end else if (stall) begin
      ex_d    = ex_q;
      valid_d = valid_q;
    end else if (hazard) begin
      ex_d    = ID_EX_BUBBLE;
      valid_d = 1'b0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_d    = id_pl;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= ID_EX_BUBBLE;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_pc4         = ex_q.pc4;
  assign ex_rd1         = ex_q.rd1;
  assign ex_rd2         = ex_q.rd2;
  assign ex_imm         = ex_q.imm;
  assign ex_rs          = ex_q.rs;
  assign ex_rt          = ex_q.rt;
  assign ex_rd          = ex_q.rd;
  assign ex_RegWrite    = ex_q.reg_write;
  assign ex_MemtoReg    = ex_q.mem_to_reg;
  assign ex_MemRead     = ex_q.mem_read;
  assign ex_MemWrite    = ex_q.mem_write;
  assign ex_Branch      = ex_q.branch;
  assign ex_ALUSrc      = ex_q.alu_src;
  assign ex_RegDst      = ex_q.reg_dst;
  assign ex_ALUOp       = ex_q.alu_op;
  assign ex_valid       = valid_q;
  assign load_use_stall = hazard;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios checked against a cycle model, with
// a narrow-counter instance to exercise saturation in few cycles.
module tb_id_ex_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite;
  logic        id_Branch, id_ALUSrc, id_RegDst;
  logic [1:0]  id_ALUOp;

  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite;
  logic        ex_Branch, ex_ALUSrc, ex_RegDst, ex_valid, load_use_stall;
  logic [1:0]  ex_ALUOp;
  logic [15:0] bubble_cnt;

  logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_RegWrite, s_MemtoReg, s_MemRead, s_MemWrite;
  logic        s_Branch, s_ALUSrc, s_RegDst, s_valid, s_lus;
  logic [1:0]  s_ALUOp;
  logic [3:0]  s_bubble_cnt;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
    .id_RegDst(id_RegDst), .id_ALUOp(id_ALUOp),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_ALUSrc(ex_ALUSrc),
    .ex_RegDst(ex_RegDst), .ex_ALUOp(ex_ALUOp), .ex_valid(ex_valid),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemRead(id_MemRead),
    .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
    .id_RegDst(id_RegDst), .id_ALUOp(id_ALUOp),
    .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_RegWrite(s_RegWrite), .ex_MemtoReg(s_MemtoReg), .ex_MemRead(s_MemRead),
    .ex_MemWrite(s_MemWrite), .ex_Branch(s_Branch), .ex_ALUSrc(s_ALUSrc),
    .ex_RegDst(s_RegDst), .ex_ALUOp(s_ALUOp), .ex_valid(s_valid),
    .load_use_stall(s_lus), .bubble_cnt(s_bubble_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the EX stage holds, as a flat record of the last accepted instruction
  typedef struct packed {
    logic        v;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [6:0]  ctrl;   // {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,RegDst}
    logic [1:0]  aop;
  } mdl_t;

  mdl_t m;
  int   m_bubbles;
  bit   m_live = 0;

  function automatic bit m_hazard();
    return m.v && m.ctrl[4] && (m.rt != 5'd0) && (m.rt == id_rs || m.rt == id_rt);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m = '0; m_bubbles = 0; m_live = 1;
    end else if (m_live) begin
      if (flush) m = '0;
      else if (stall) m = m;
      else if (m_hazard()) begin m = '0; m_bubbles++; end
      else m = '{1'b1, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
                 {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst},
                 id_ALUOp};
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cyc_valid", 64'(ex_valid), 64'(m.v));
      check("cyc_pc4",   64'(ex_pc4),   64'(m.pc4));
      check("cyc_rd1",   64'(ex_rd1),   64'(m.rd1));
      check("cyc_rd2",   64'(ex_rd2),   64'(m.rd2));
      check("cyc_imm",   64'(ex_imm),   64'(m.imm));
      check("cyc_regs",  64'({ex_rs, ex_rt, ex_rd}), 64'({m.rs, m.rt, m.rd}));
      check("cyc_ctrl",  64'({ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch,
                              ex_ALUSrc, ex_RegDst}), 64'(m.ctrl));
      check("cyc_aluop", 64'(ex_ALUOp), 64'(m.aop));
      check("cyc_lus",   64'(load_use_stall), 64'(m_hazard()));
      check("cyc_cnt16", 64'(bubble_cnt), 64'((m_bubbles > 65535) ? 65535 : m_bubbles));
      check("cyc_cnt4",  64'(s_bubble_cnt), 64'((m_bubbles > 15) ? 15 : m_bubbles));
      check("cyc_s_ex",  64'({s_valid, s_rs, s_rt, s_MemRead}), 64'({ex_valid, ex_rs, ex_rt, ex_MemRead}));
    end
  end

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RW   = 7'b1000000;
  localparam logic [6:0] C_LW   = 7'b1110010;
  localparam logic [6:0] C_RT   = 7'b1000001;

  task automatic drive(input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [6:0] c, input logic [1:0] aop);
    id_pc4 = pc4; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
    {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUSrc, id_RegDst} = c;
    id_ALUOp = aop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'h1234, 32'h1, 32'h2, 32'h3, 5'd8, 5'd8, 5'd9, C_LW, 2'b00);
    tick(); tick();
    check("rst_valid", 64'(ex_valid), 64'(0));
    check("rst_cnt",   64'(bubble_cnt), 64'(0));
    check("rst_ctrl",  64'({ex_RegWrite, ex_MemRead, ex_pc4}), 64'(0));
    reset = 1'b0;
    check("rst_lus",   64'(load_use_stall), 64'(0));

    // basic load, 1-cycle latency
    drive(32'h4, 32'h0000_00AA, 32'h0000_0055, 32'h0, 5'd1, 5'd2, 5'd3, C_RW, 2'b10);
    tick();
    check("load_rd1", 64'(ex_rd1), 64'h0AA);
    check("load_rd2", 64'(ex_rd2), 64'h055);
    check("load_rw",  64'(ex_RegWrite), 64'(1));
    check("load_vld", 64'(ex_valid), 64'(1));

    // lw $8 followed by a consumer of $8
    drive(32'h8, 32'h10, 32'h20, 32'h4, 5'd1, 5'd8, 5'd0, C_LW, 2'b00);
    tick();
    drive(32'hC, 32'h30, 32'h40, 32'h0, 5'd8, 5'd3, 5'd4, C_RT, 2'b10);
    #1 check("haz_lus", 64'(load_use_stall), 64'(1));
    tick();
    check("haz_vld",  64'(ex_valid), 64'(0));
    check("haz_ctrl", 64'({ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_ALUSrc}), 64'(0));
    check("haz_cnt",  64'(bubble_cnt), 64'(1));
    tick();
    check("haz_reload", 64'({ex_valid, ex_pc4}), {31'd0, 1'b1, 32'hC});

    // lw $0 never stalls
    drive(32'h10, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, C_LW, 2'b00);
    tick();
    drive(32'h14, 32'h5, 32'h6, 32'h0, 5'd0, 5'd0, 5'd7, C_RT, 2'b10);
    #1 check("zero_lus", 64'(load_use_stall), 64'(0));
    tick();
    check("zero_load", 64'({ex_valid, ex_pc4}), {31'd0, 1'b1, 32'h14});
    check("zero_cnt",  64'(bubble_cnt), 64'(1));

    // stall holds EX even with a pending hazard
    drive(32'h100, 32'h0, 32'h0, 32'h0, 5'd2, 5'd8, 5'd0, C_LW, 2'b00);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h200 + 32'(i), 32'hF0 + 32'(i), 32'h0, 32'h0, 5'd8, 5'd1, 5'd1, C_RT, 2'b10);
      tick();
      check("stall_pc4", 64'(ex_pc4), 64'h100);
      check("stall_cnt", 64'(bubble_cnt), 64'(1));
    end

    // flush beats stall and hazard, without counting
    flush = 1'b1;
    tick();
    check("flush_vld", 64'({ex_valid, ex_MemRead, ex_pc4}), 64'(0));
    check("flush_cnt", 64'(bubble_cnt), 64'(1));
    flush = 1'b0; stall = 1'b0;

    // repeated self-dependent loads: 20 more bubbles
    drive(32'h300, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0, C_LW, 2'b00);
    for (int i = 0; i < 40; i++) tick();
    check("sat_cnt16", 64'(bubble_cnt), 64'(21));
    check("sat_cnt4",  64'(s_bubble_cnt), 64'hF);

    // reset mid-stall discards the held load
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    check("rst2_vld", 64'({ex_valid, ex_MemRead, ex_pc4}), 64'(0));
    check("rst2_cnt", 64'({bubble_cnt, s_bubble_cnt}), 64'(0));
    stall = 1'b0; reset = 1'b0;
    drive(32'h44, 32'hAA, 32'h55, 32'h0, 5'd1, 5'd2, 5'd3, C_RW, 2'b00);
    tick();
    check("rst2_load", 64'({ex_valid, ex_pc4}), {31'd0, 1'b1, 32'h44});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
